// File: rtl/rs_entry_tracker_pkg.sv
// Shared constants and index type for the reservation-station entry tracker.
package rs_entry_tracker_pkg;

  localparam int RS_ENTRIES     = 16;
  localparam int RS_ALLOC_WIDTH = 2;
  localparam int RS_FREE_PORTS  = 3;

  typedef logic [$clog2(RS_ENTRIES)-1:0] rs_idx_t;

endpackage

// File: rtl/rs_free_picker.sv
// Combinational picker: serves requesting lanes in ascending order with the
// lowest-numbered free entries; non-requesting lanes consume nothing.
module rs_free_picker #(
  parameter int  RS_ENTRIES  = 16,
  parameter int  ALLOC_WIDTH = 2,
  localparam int IDX_W       = $clog2(RS_ENTRIES)
) (
  input  logic [RS_ENTRIES-1:0]        occupied_i,
  input  logic [ALLOC_WIDTH-1:0]       req_i,
  output logic [ALLOC_WIDTH-1:0]       gnt_o,
  output logic [ALLOC_WIDTH*IDX_W-1:0] index_o
);

  logic [RS_ENTRIES-1:0] avail;
  logic                  found;

  always_comb begin
    avail   = ~occupied_i;
    gnt_o   = '0;
    index_o = '0;
    found   = 1'b0;
    for (int k = 0; k < ALLOC_WIDTH; k++) begin
      found = 1'b0;
      for (int i = 0; i < RS_ENTRIES; i++) begin
        // Claimed entries are removed from avail so later lanes see the next one.
        if (req_i[k] && !found && avail[i]) begin
          found                      = 1'b1;
          gnt_o[k]                   = 1'b1;
          index_o[k*IDX_W +: IDX_W]  = IDX_W'(i);
          avail[i]                   = 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/rs_entry_tracker.sv
// Reservation-station occupancy tracker: multi-lane allocation, multi-channel free.
// Optional sticky illegal-free detection is compiled in with RS_FREE_CHECK_EN.
module rs_entry_tracker #(
  parameter int  RS_ENTRIES     = rs_entry_tracker_pkg::RS_ENTRIES,
  parameter int  ALLOC_WIDTH    = rs_entry_tracker_pkg::RS_ALLOC_WIDTH,
  parameter int  NUM_FREE_PORTS = rs_entry_tracker_pkg::RS_FREE_PORTS,
  localparam int IDX_W          = $clog2(RS_ENTRIES),
  localparam int CNT_W          = $clog2(RS_ENTRIES+1)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            flush,
  input  logic [ALLOC_WIDTH-1:0]          alloc_req,
  output logic [ALLOC_WIDTH-1:0]          alloc_gnt,
  output logic [ALLOC_WIDTH*IDX_W-1:0]    alloc_index,
  input  logic [NUM_FREE_PORTS-1:0]       free_en,
  input  logic [NUM_FREE_PORTS*IDX_W-1:0] free_index,
  output logic [RS_ENTRIES-1:0]           occupied,
  output logic [CNT_W-1:0]                free_count,
  output logic                            full,
  output logic                            empty
`ifdef RS_FREE_CHECK_EN
  ,output logic                           free_err
`endif
);

  logic [RS_ENTRIES-1:0]  occ_q, occ_d;
  logic [RS_ENTRIES-1:0]  alloc_mask, free_mask;
  logic [CNT_W-1:0]       free_count_q, free_count_d, occ_cnt;
  logic [ALLOC_WIDTH-1:0] pick_gnt;
  logic                   hold;

  // Handshake: a lane owns alloc_index whenever alloc_req and alloc_gnt are both
  // high in the same cycle; there is no back-pressure, the entry is taken at the edge.
  rs_free_picker #(
    .RS_ENTRIES  (RS_ENTRIES),
    .ALLOC_WIDTH (ALLOC_WIDTH)
  ) u_picker (
    .occupied_i (occ_q),
    .req_i      (alloc_req),
    .gnt_o      (pick_gnt),
    .index_o    (alloc_index)
  );

  assign hold      = rst | flush;
  assign alloc_gnt = hold ? '0 : pick_gnt;

  // Index matching by comparison makes out-of-range frees hit nothing.
  always_comb begin
    alloc_mask = '0;
    free_mask  = '0;
    for (int i = 0; i < RS_ENTRIES; i++) begin
      for (int k = 0; k < ALLOC_WIDTH; k++) begin
        if (alloc_gnt[k] && alloc_index[k*IDX_W +: IDX_W] == IDX_W'(i)) alloc_mask[i] = 1'b1;
      end
      for (int c = 0; c < NUM_FREE_PORTS; c++) begin
        if (free_en[c] && free_index[c*IDX_W +: IDX_W] == IDX_W'(i)) free_mask[i] = 1'b1;
      end
    end
    occ_d = flush ? '0 : ((occ_q & ~free_mask) | alloc_mask);
  end

  always_comb begin
    occ_cnt = '0;
    for (int i = 0; i < RS_ENTRIES; i++) occ_cnt = occ_cnt + CNT_W'(occ_d[i]);
    free_count_d = CNT_W'(RS_ENTRIES) - occ_cnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q        <= '0;
      free_count_q <= CNT_W'(RS_ENTRIES);
    end else begin
      occ_q        <= occ_d;
      free_count_q <= free_count_d;
    end
  end

  assign occupied   = occ_q;
  assign free_count = free_count_q;
  assign full       = (free_count_q == '0);
  assign empty      = (free_count_q == CNT_W'(RS_ENTRIES));

`ifdef RS_FREE_CHECK_EN
  logic                      err_q, err_d;
  logic [NUM_FREE_PORTS-1:0] legal;

  // A free is legal only if it names an in-range entry that is occupied now.
  always_comb begin
    err_d = 1'b0;
    legal = '0;
    for (int c = 0; c < NUM_FREE_PORTS; c++) begin
      for (int i = 0; i < RS_ENTRIES; i++) begin
        if (free_index[c*IDX_W +: IDX_W] == IDX_W'(i) && occ_q[i]) legal[c] = 1'b1;
      end
      if (free_en[c] && !legal[c]) err_d = 1'b1;
      for (int d = c + 1; d < NUM_FREE_PORTS; d++) begin
        if (free_en[c] && free_en[d] &&
            free_index[c*IDX_W +: IDX_W] == free_index[d*IDX_W +: IDX_W]) err_d = 1'b1;
      end
    end
    if (flush) err_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst)        err_q <= 1'b0;
    else if (err_d) err_q <= 1'b1;
  end

  assign free_err = err_q;
`endif

endmodule

// File: doc/rs_entry_tracker.md
Name: rs_entry_tracker

Overview:
Tracks occupancy of reservation-station entries. Hands up to ALLOC_WIDTH free entry indices per cycle to Dispatch, and retires up to NUM_FREE_PORTS entries per cycle from Execute (one free port per execute channel). It replaces the single-channel free path with a multi-channel, parametrised allocator and free list. It sits between Dispatch, the Wakeup reservation stations, and the Execute completion ports.

Parameters:
- RS_ENTRIES, 16: number of RS entries; any value >= 2, not required to be a power of two.
- ALLOC_WIDTH, 2: dispatch allocation lanes per cycle, 1..4.
- NUM_FREE_PORTS, 3: execute free channels per cycle, 1..8.
- IDX_W, $clog2(RS_ENTRIES): entry index width; derived, never overridden.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  pipeline flush; releases every entry
- alloc_req  in  ALLOC_WIDTH  per-lane allocation request from Dispatch
- alloc_gnt  out  ALLOC_WIDTH  per-lane grant, combinational
- alloc_index  out  ALLOC_WIDTH*IDX_W  granted index per lane; lane k occupies bits [k*IDX_W +: IDX_W]
- free_en  in  NUM_FREE_PORTS  per-channel free strobe from Execute
- free_index  in  NUM_FREE_PORTS*IDX_W  per-channel index to free
- occupied  out  RS_ENTRIES  registered occupancy vector
- free_count  out  $clog2(RS_ENTRIES+1)  registered count of free entries
- full  out  1  free_count == 0
- empty  out  1  free_count == RS_ENTRIES
- free_err  out  1  sticky illegal-free flag; present only with RS_FREE_CHECK_EN

Behaviour:
- Clock and reset: single clock clk. rst is synchronous and active-high.
- Reset values: occupied = 0, free_count = RS_ENTRIES, full = 0, empty = 1, free_err = 0. alloc_gnt = 0 during any cycle in which rst = 1.
- Allocation ordering: lanes are served in ascending lane order.
  - The j-th requesting lane (j counted from 0) is granted iff at least j+1 entries are free in the registered occupied vector.
  - That lane receives the j-th lowest-numbered free index.
  - Non-requesting lanes are skipped and consume no entry.
  - Lanes left unserved once free entries run out get gnt = 0.
- alloc_index for a lane with gnt = 0 is don't-care; the bench checks it only when gnt = 1.
- Allocation timing: the grant and index are combinational in the request cycle. The entry is marked occupied at the next rising edge. Latency from request to the occupied update is 1 cycle.
- Free: for each channel with free_en set, occupied[free_index] clears at the next edge.
- Freed entries are not allocatable in the same cycle; they become visible the cycle after the free.
- Simultaneous allocation and free in one cycle: both apply, and free_count is updated accordingly.
  - The same index cannot be both allocated and freed in one cycle, because allocation only picks entries that are currently free.
- Two channels freeing the same index in one cycle: the entry is cleared once and free_count increments by 1, not 2.
- free_count is recomputed from the next occupancy state (population count). It is never incrementally accumulated, so no drift is possible.
- full and empty are derived from the registered free_count.
- flush (when rst = 0):
  - alloc_gnt = 0 in the flush cycle.
  - free_en is ignored.
  - Next state: occupied = 0, free_count = RS_ENTRIES.
  - free_err is not cleared.
- rst has priority over flush.
- Out-of-range free_index (>= RS_ENTRIES when RS_ENTRIES is not a power of two) is ignored.
- No internal FSM beyond the occupancy register. Mode is implicit: normal / flush / reset.

Optional Feature:
RS_FREE_CHECK_EN
- When defined: free_err sets at the next edge and stays set until rst if any of these occur:
  - free_en targets an entry that is currently not occupied.
  - Two enabled channels carry the same index in one cycle.
  - free_index is out of range.
- Frees ignored under flush never raise free_err.
- When not defined: the free_err port and its checking logic are absent, and illegal frees are silently tolerated as described above.

Decomposition:
- CORE_PKG holds the shared constants and type: RS_ENTRIES, RS_ALLOC_WIDTH, RS_FREE_PORTS, and typedef rs_idx_t = logic [$clog2(RS_ENTRIES)-1:0].
- One sub-module, rs_free_picker: purely combinational. Given the occupancy vector and alloc_req, it returns the grants and the ALLOC_WIDTH lowest free indices in lane order.
- The tracker top holds the register, the free-merge logic, the population count, flush/reset handling, and the checker.

Test Plan:
All scenarios use RS_ENTRIES=8, ALLOC_WIDTH=2, NUM_FREE_PORTS=2.
- Reset, then alloc_req=2'b11 -> gnt=11, indices 0 and 1; next cycle occupied=8'h03, free_count=6.
- Fill to occupied=8'h7F, then alloc_req=11 -> gnt=01 with lane0 index 7; next cycle full=1, and alloc_req=11 -> gnt=00.
- occupied=8'hFF; free_en=11 with indices 2 and 5 while alloc_req=01 -> gnt=0 that cycle; next cycle occupied=8'hDB, free_count=2, alloc_req=11 -> indices 2 and 5.
- alloc_req=2'b10 with occupied=8'h01 -> gnt=10, lane1 index 1; lane0 unchanged.
- Both channels free index 3 (occupied=8'h0F) -> occupied=8'h07, free_count=5; with RS_FREE_CHECK_EN, free_err=1 and stays 1 until rst.
- flush with occupied=8'hF0 and alloc_req=11 -> gnt=00; next cycle occupied=0, empty=1, free_count=8; rst and flush asserted together -> reset values, free_err=0.
